// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-port (fetch / data) arbiter in front of a single fixed-latency memory.
// Ties go to the port not served last; every access occupies LAT memory cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  // Data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // Shared memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  localparam logic [3:0] LatM1 = 4'(LAT - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              last_d_q;
  logic              i_gnt_q, d_gnt_q, i_done_q, d_done_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      last_d_q    <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // D wins when alone, or on a tie when fetch was served last.
          if (d_req && (!i_req || !last_d_q)) begin
            state_q     <= StServeD;
            cnt_q       <= LatM1;
            last_d_q    <= 1'b1;
            d_gnt_q     <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_req) begin
            state_q    <= StServeI;
            cnt_q      <= LatM1;
            last_d_q   <= 1'b0;
            i_gnt_q    <= 1'b1;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr;
          end
        end
        StServeI, StServeD: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StIdle;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (state_q == StServeI) begin
              i_done_q  <= 1'b1;
              i_rdata_q <= mem_rdata;
            end else begin
              d_done_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: table of single transactions plus hand sequences for
// tie-break, alternation, reset abort and LAT=1, with a done-pulse scoreboard.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_done, d_gnt, d_done, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic        i_gnt1, i_done1, d_gnt1, d_done1, mem_en1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata  = mem_model(mem_addr);
  assign mem_rdata1 = mem_model(mem_addr1);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] rdata;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         e_mon;
  logic [31:0] mdl_i_rdata = '0;
  logic [31:0] mdl_d_rdata = '0;
  logic        mdl_last_d  = 1'b0;

  // Scoreboard: every done pulse must match the oldest outstanding transaction.
  always @(negedge clk) begin
    if (reset && (i_done || d_done)) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {62'd0, i_done, d_done}, 64'd0);
      end else begin
        e_mon = sb_q.pop_front();
        chk("sb_port", {62'd0, i_done, d_done}, e_mon.is_d ? 64'd1 : 64'd2);
        if (e_mon.is_d) begin
          if (!e_mon.we) mdl_d_rdata = e_mon.rdata;
          chk("sb_d_rdata", d_rdata, mdl_d_rdata);
        end else begin
          mdl_i_rdata = e_mon.rdata;
          chk("sb_i_rdata", i_rdata, mdl_i_rdata);
        end
      end
    end
  end

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        exp_d;
  } vec_t;

  vec_t vecs[7];

  task automatic push_txn(input logic is_d, input logic we, input logic [31:0] addr);
    sb_t e;
    e.is_d  = is_d;
    e.we    = we;
    e.rdata = mem_model(addr);
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {62'd0, i_gnt, d_gnt}, 64'd0);
    chk({tag, "_done"}, {62'd0, i_done, d_done}, 64'd0);
    chk({tag, "_mem_en_we"}, {62'd0, mem_en, mem_we}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    chk({tag, "_mem_addr_wdata"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] exp_addr;
    logic        exp_we;
    exp_addr = v.exp_d ? v.d_addr : v.i_addr;
    exp_we   = v.exp_d & v.d_we;
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    push_txn(v.exp_d, exp_we, exp_addr);
    @(negedge clk);
    chk($sformatf("v%0d_c0_gnt", idx), {62'd0, i_gnt, d_gnt}, 64'd0);
    chk($sformatf("v%0d_c0_busy", idx), {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_c1_gnt", idx), {62'd0, i_gnt, d_gnt}, v.exp_d ? 64'd1 : 64'd2);
    chk($sformatf("v%0d_c1_busy", idx), {63'd0, busy}, 64'd1);
    chk($sformatf("v%0d_c1_addr", idx), mem_addr, exp_addr);
    if (exp_we) chk($sformatf("v%0d_c1_wdata", idx), mem_wdata, v.d_wdata);
    for (int c = 1; c <= int'(LAT); c++) begin
      if (c > 1) begin
        @(negedge clk);
        chk($sformatf("v%0d_c%0d_gnt", idx, c), {62'd0, i_gnt, d_gnt}, 64'd0);
      end
      chk($sformatf("v%0d_c%0d_en_we", idx, c), {62'd0, mem_en, mem_we}, {62'd0, 1'b1, exp_we});
    end
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), {62'd0, i_done, d_done}, v.exp_d ? 64'd1 : 64'd2);
    chk($sformatf("v%0d_end_en_we_busy", idx), {61'd0, mem_en, mem_we, busy}, 64'd0);
    if (v.exp_d) chk($sformatf("v%0d_i_rdata_hold", idx), i_rdata, mdl_i_rdata);
    else         chk($sformatf("v%0d_d_rdata_hold", idx), d_rdata, mdl_d_rdata);
    mdl_last_d = v.exp_d;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_flags;
    logic       exp_d;
    int         ngr;

    //              i_req i_addr      d_req d_we d_addr      d_wdata       exp_d
    vecs[0] = '{1'b1, 32'h10,    1'b0, 1'b0, 32'h0,  32'h0,       1'b0};
    vecs[1] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h20, 32'h55,      1'b1};
    vecs[2] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h30, 32'h0,       1'b1};
    vecs[3] = '{1'b1, 32'h40,    1'b1, 1'b0, 32'h44, 32'h0,       1'b0};
    vecs[4] = '{1'b1, 32'h1234,  1'b1, 1'b1, 32'h48, 32'hCAFE,    1'b1};
    vecs[5] = '{1'b1, 32'h1234,  1'b0, 1'b0, 32'h0,  32'h0,       1'b0};
    vecs[6] = '{1'b1, 32'h2000,  1'b1, 1'b0, 32'h50, 32'h0,       1'b1};

    // Reset state
    #3;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    mdl_last_d = 1'b0;

    // Tie right after reset: D first, then the held fetch request back-to-back.
    i_req = 1'b1; i_addr = 32'h70;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h74;
    push_txn(1'b1, 1'b0, 32'h74);
    push_txn(1'b0, 1'b0, 32'h70);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_flags = {c == 4, c == 6, c == 1, c == 3};
      chk($sformatf("tie_c%0d", c), {60'd0, i_gnt, i_done, d_gnt, d_done}, {60'd0, exp_flags});
      @(posedge clk); #1;
      if (c == 0) d_req = 1'b0;
      if (c == 3) i_req = 1'b0;
    end
    mdl_last_d = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Both ports re-requesting continuously: grants must alternate.
    exp_d = !mdl_last_d;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
    for (int k = 0; k < 8; k++) push_txn(exp_d ^ k[0], 1'b0, (exp_d ^ k[0]) ? 32'h84 : 32'h80);
    ngr = 0;
    for (int c = 0; c < 8 * (int'(LAT) + 1) + 4 && ngr < 8; c++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        chk($sformatf("alt_gnt%0d", ngr), {62'd0, i_gnt, d_gnt}, exp_d ? 64'd1 : 64'd2);
        mdl_last_d = exp_d;
        exp_d = !exp_d;
        ngr++;
        if (ngr == 8) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("alt_count", 64'(ngr), 64'd8);
    repeat (int'(LAT) + 2) @(negedge clk);
    chk("alt_sb_drained", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a data read aborts it without a done pulse.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    push_txn(1'b1, 1'b0, 32'h90);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("abort_c1_gnt", {63'd0, d_gnt}, 64'd1);
    @(posedge clk); #1;
    chk("abort_c2_en", {62'd0, mem_en, busy}, 64'd3);
    reset = 1'b0;
    #1;
    chk_reset_outputs("abort");
    sb_q.delete();
    mdl_i_rdata = '0;
    mdl_d_rdata = '0;
    mdl_last_d  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done%0d", c), {61'd0, d_done, i_done, busy}, 64'd0);
    end
    @(posedge clk); #1;

    // LAT=1 instance: single memory cycle, done right after.
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'hA0;
    @(negedge clk);
    chk("lat1_c0_gnt", {63'd0, d_gnt1}, 64'd0);
    @(posedge clk); #1;
    d_req1 = 1'b0;
    @(negedge clk);
    chk("lat1_c1", {61'd0, d_gnt1, mem_en1, d_done1}, 64'd6);
    chk("lat1_c1_addr", mem_addr1, 32'hA0);
    @(negedge clk);
    chk("lat1_c2", {60'd0, d_gnt1, mem_en1, d_done1, busy1}, 64'd2);
    chk("lat1_c2_rdata", d_rdata1, mem_model(32'hA0));
    @(negedge clk);
    chk("lat1_c3", {62'd0, d_done1, busy1}, 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter LAT, default 2, memory access cycles per transaction; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 i_req  input  1  instruction-fetch request, held until i_gnt.
REQ-007 i_addr  input  ADDR_W  fetch address, valid while i_req=1.
REQ-008 i_gnt  output  1  one-cycle grant pulse to fetch port.
REQ-009 i_done  output  1  one-cycle completion pulse to fetch port.
REQ-010 i_rdata  output  DATA_W  fetched word, registered.
REQ-011 d_req  input  1  data request, held until d_gnt.
REQ-012 d_we  input  1  1=write, 0=read, valid while d_req=1.
REQ-013 d_addr / d_wdata  input  ADDR_W / DATA_W  data address and write data.
REQ-014 d_gnt / d_done  output  1 each  data grant / completion pulses.
REQ-015 d_rdata  output  DATA_W  data-read word, registered.
REQ-016 mem_en / mem_we  output  1 each  shared memory strobe / write enable.
REQ-017 mem_addr / mem_wdata  output  ADDR_W / DATA_W  registered memory address / write data.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid on last access cycle.
REQ-019 busy  output  1  1 whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, SERVE_I, SERVE_D.
REQ-021 Requests SHALL be sampled only in IDLE; SERVE states ignore i_req/d_req.
REQ-022 IDLE, one request: next state is SERVE of that port.
REQ-023 IDLE, both requests: port not served last wins; last_served resets to I, so first tie goes to D.
REQ-024 On IDLE->SERVE edge, winner's addr/we/wdata SHALL be latched into mem_addr/mem_we/mem_wdata; last_served updated.
REQ-025 x_gnt SHALL be 1 exactly in first SERVE_x cycle; requester drops x_req there, a req still high afterwards is a new request.
REQ-026 mem_en SHALL be 1 for exactly LAT cycles (all of SERVE); mem_we = latched d_we in SERVE_D, 0 in SERVE_I.
REQ-027 A 4-bit counter SHALL load LAT-1 on entry and decrement each SERVE cycle; SERVE exits to IDLE when counter=0.
REQ-028 On exit edge of a read, mem_rdata SHALL be captured into i_rdata (SERVE_I) or d_rdata (SERVE_D).
REQ-029 x_done SHALL be 1 for one cycle, the IDLE cycle after SERVE exit; x_rdata valid from then until next read completion on that port.
REQ-030 Writes SHALL assert d_done but leave d_rdata unchanged.
REQ-031 Back-to-back: the done cycle's IDLE samples requests, so a new grant follows done in the next cycle; throughput one transaction per LAT+1 cycles.
REQ-032 Latency: req sampled at edge N -> gnt in cycle N+1, done in cycle N+1+LAT.
REQ-033 Outside SERVE, mem_en=0 and mem_we=0; mem_addr/mem_wdata hold last value.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, counter 0, last_served=I, all outputs 0 (gnt, done, mem_en, mem_we, busy, rdata, mem_addr, mem_wdata).
REQ-035 Reset during SERVE SHALL abort the access; no done pulse SHALL follow reset release.
REQ-036 First request sampling SHALL occur on the first rising edge with reset=1.

Verification (LAT=2 unless stated)
REQ-037 I read: i_req, i_addr=0x10, mem_rdata=0xDEADBEEF -> i_gnt cycle 1, mem_en cycles 1-2 with mem_addr=0x10, i_done cycle 3, i_rdata=0xDEADBEEF.
REQ-038 Tie after reset: i_req and d_req at cycle 0 -> d_gnt cycle 1, d_done cycle 3, i_gnt cycle 4, i_done cycle 6.
REQ-039 D write d_addr=0x20, d_wdata=0x55 -> mem_we=1 and mem_wdata=0x55 cycles 1-2, d_done cycle 3, d_rdata unchanged.
REQ-040 Both requests re-asserted after every grant for 8 transactions -> grants alternate D,I,D,I,..., no port granted twice in a row.
REQ-041 reset=0 mid SERVE_D (cycle 2) -> mem_en, busy, d_gnt immediately 0; after release with no requests, d_done stays 0.
REQ-042 LAT=1: d_req -> d_gnt cycle 1, mem_en cycle 1 only, d_done cycle 2.
